// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: cache line refill / victim write-back engine.
// Accepts one fetch request per transaction. A dirty victim (cmd 2'b10) is first
// streamed from cache data memory to the external write channel; then the new
// line is fetched over the external read channel, written into the data-memory
// slot selected by the tag, and fetch_done pulses for one cycle.
// Ports:
//   fetch_*   : request side (req/cmd/tag/addr/addr_pre in, gnt/done out)
//   mem_r*    : data-memory read of victim words (raddr/ren out, rready/rdata/rdata_valid in)
//   mem_w*    : data-memory write of refill words (waddr/wen/wdata out, wready in)
//   ext_rd_*  : external line read (req/addr/ready out, gnt/data/valid in)
//   ext_wr_*  : external write-back beats (valid/addr/data/last out, ready in)
module line_fill_ctrl #(
  parameter int unsigned addr_width = 32,
  parameter int unsigned list_depth = 4,
  parameter int unsigned data_width = 32,
  parameter int unsigned list_width = 32,
  localparam int unsigned tag_w     = $clog2(list_depth),
  localparam int unsigned cnt_w     = $clog2(list_width),
  localparam int unsigned maddr_w   = tag_w + cnt_w
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch request interface
  input  logic                  fetch_req,
  input  logic [1:0]            fetch_cmd,
  input  logic [tag_w-1:0]      fetch_tag,
  input  logic [addr_width-1:0] fetch_addr,
  input  logic [addr_width-1:0] fetch_addr_pre,
  output logic                  fetch_gnt,
  output logic                  fetch_done,
  // cache data memory read (victim)
  output logic [maddr_w-1:0]    mem_raddr,
  output logic                  mem_ren,
  input  logic                  mem_rready,
  input  logic [data_width-1:0] mem_rdata,
  input  logic                  mem_rdata_valid,
  // cache data memory write (refill)
  output logic [maddr_w-1:0]    mem_waddr,
  output logic                  mem_wen,
  output logic [data_width-1:0] mem_wdata,
  input  logic                  mem_wready,
  // external read channel
  output logic                  ext_rd_req,
  output logic [addr_width-1:0] ext_rd_addr,
  input  logic                  ext_rd_gnt,
  input  logic [data_width-1:0] ext_rd_data,
  input  logic                  ext_rd_valid,
  output logic                  ext_rd_ready,
  // external write channel
  output logic                  ext_wr_valid,
  output logic [addr_width-1:0] ext_wr_addr,
  output logic [data_width-1:0] ext_wr_data,
  output logic                  ext_wr_last,
  input  logic                  ext_wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WB_RD   = 3'd1,
    S_WB_WAIT = 3'd2,
    S_WB_PUSH = 3'd3,
    S_RD_REQ  = 3'd4,
    S_FILL    = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [cnt_w-1:0]      cnt_q, cnt_d;
  logic [tag_w-1:0]      tag_q, tag_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width-1:0] addr_pre_q, addr_pre_d;
  logic [data_width-1:0] wr_data_q, wr_data_d;

  logic cnt_last;
  assign cnt_last = (cnt_q == cnt_w'(list_width - 1));

  // Address/data outputs come straight from the transaction latches.
  assign ext_rd_addr = addr_q;
  assign ext_wr_addr = addr_pre_q;
  assign ext_wr_data = wr_data_q;

  // State and transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tag_q      <= '0;
      addr_q     <= '0;
      addr_pre_q <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      addr_pre_q <= addr_pre_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tag_d        = tag_q;
    addr_d       = addr_q;
    addr_pre_d   = addr_pre_q;
    wr_data_d    = wr_data_q;
    fetch_gnt    = 1'b0;
    fetch_done   = 1'b0;
    mem_ren      = 1'b0;
    mem_raddr    = '0;
    mem_wen      = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    ext_rd_req   = 1'b0;
    ext_rd_ready = 1'b0;
    ext_wr_valid = 1'b0;
    ext_wr_last  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        fetch_gnt = fetch_req;
        if (fetch_req) begin
          tag_d      = fetch_tag;
          addr_d     = fetch_addr;
          addr_pre_d = fetch_addr_pre;
          cnt_d      = '0;
          state_d    = (fetch_cmd == 2'b10) ? S_WB_RD : S_RD_REQ;
        end
      end

      S_WB_RD: begin
        mem_ren   = 1'b1;
        mem_raddr = {tag_q, cnt_q};
        if (mem_rready) begin
          state_d = S_WB_WAIT;
        end
      end

      S_WB_WAIT: begin
        if (mem_rdata_valid) begin
          wr_data_d = mem_rdata;
          state_d   = S_WB_PUSH;
        end
      end

      // Victim beat is held in wr_data_q until the write channel takes it.
      S_WB_PUSH: begin
        ext_wr_valid = 1'b1;
        ext_wr_last  = cnt_last;
        if (ext_wr_ready) begin
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_RD_REQ;
          end else begin
            cnt_d   = cnt_q + cnt_w'(1);
            state_d = S_WB_RD;
          end
        end
      end

      S_RD_REQ: begin
        ext_rd_req = 1'b1;
        if (ext_rd_gnt) begin
          state_d = S_FILL;
        end
      end

      // Refill beats pass straight through to the data memory when it can accept.
      S_FILL: begin
        ext_rd_ready = mem_wready;
        if (ext_rd_valid && mem_wready) begin
          mem_wen   = 1'b1;
          mem_waddr = {tag_q, cnt_q};
          mem_wdata = ext_rd_data;
          if (cnt_last) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q + cnt_w'(1);
          end
        end
      end

      S_DONE: begin
        fetch_done = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Scoreboard bench for line_fill_ctrl: stimulus pushes expected memory writes,
// write-back beats and done latencies; a negedge monitor pops and compares.
module tb_line_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_req;
  logic [1:0]  fetch_cmd;
  logic [1:0]  fetch_tag;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_addr_pre;
  logic        fetch_gnt;
  logic        fetch_done;
  logic [6:0]  mem_raddr;
  logic        mem_ren;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;
  logic [6:0]  mem_waddr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic        mem_wready;
  logic        ext_rd_req;
  logic [31:0] ext_rd_addr;
  logic        ext_rd_gnt;
  logic [31:0] ext_rd_data;
  logic        ext_rd_valid;
  logic        ext_rd_ready;
  logic        ext_wr_valid;
  logic [31:0] ext_wr_addr;
  logic [31:0] ext_wr_data;
  logic        ext_wr_last;
  logic        ext_wr_ready;

  line_fill_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag),
    .fetch_addr(fetch_addr), .fetch_addr_pre(fetch_addr_pre),
    .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .mem_raddr(mem_raddr), .mem_ren(mem_ren), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .mem_waddr(mem_waddr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready),
    .ext_rd_req(ext_rd_req), .ext_rd_addr(ext_rd_addr), .ext_rd_gnt(ext_rd_gnt),
    .ext_rd_data(ext_rd_data), .ext_rd_valid(ext_rd_valid), .ext_rd_ready(ext_rd_ready),
    .ext_wr_valid(ext_wr_valid), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .ext_wr_last(ext_wr_last), .ext_wr_ready(ext_wr_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int gnt_cyc = 0;
  int done_cyc = 0;
  bit bp = 0;
  int gnt_delay = 0;
  bit b2b_armed = 0;
  bit b2b_wait  = 0;

  logic [38:0] exp_mem[$];   // {waddr, wdata}
  logic [64:0] exp_wr[$];    // {addr, data, last}
  int          exp_done[$];  // gnt->done latency, -1 = presence only

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_fill(input logic [1:0] tag, input logic [31:0] addr, input int n);
    for (int i = 0; i < n; i++) exp_mem.push_back({tag, 5'(i), addr + 32'(i)});
  endtask

  task automatic push_wb(input logic [31:0] pre);
    for (int i = 0; i < 32; i++) exp_wr.push_back({pre, 32'hA0 + 32'(i), (i == 31)});
  endtask

  task automatic wait_gnt(input string name);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = fetch_gnt;
    end
    check(name, 128'(seen), 128'(1));
  endtask

  // Issue one request, then scramble the fetch inputs once it is granted.
  task automatic issue(input logic [1:0] cmd, input logic [1:0] tag,
                       input logic [31:0] addr, input logic [31:0] pre);
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_cmd = cmd; fetch_tag = tag;
    fetch_addr = addr; fetch_addr_pre = pre;
    wait_gnt("gnt_seen");
    @(posedge clk); #1;
    fetch_req = 1'b0; fetch_cmd = ~cmd; fetch_tag = ~tag;
    fetch_addr = ~addr; fetch_addr_pre = ~pre;
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (exp_done.size() == 0 && exp_mem.size() == 0 && exp_wr.size() == 0) break;
    end
    check(name, 128'(exp_done.size() + exp_mem.size() + exp_wr.size()), 128'(0));
    exp_done.delete(); exp_mem.delete(); exp_wr.delete();
  endtask

  // Memory / external slave models. Sample at negedge, drive after posedge.
  initial begin : slaves
    bit s_rst, s_rd_fire, s_fill_fire, s_req, s_gnt;
    logic [6:0]  s_raddr;
    logic [31:0] s_addr;
    logic [31:0] fill_base;
    int beat, req_cnt;
    beat = 0; req_cnt = 0; fill_base = '0;
    mem_rready = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0; mem_wready = 1'b0;
    ext_rd_gnt = 1'b0; ext_rd_data = '0; ext_rd_valid = 1'b0; ext_wr_ready = 1'b0;
    forever begin
      @(negedge clk);
      s_rst       = !rst_n;
      s_rd_fire   = mem_ren && mem_rready;
      s_raddr     = mem_raddr;
      s_fill_fire = ext_rd_valid && ext_rd_ready;
      s_req       = ext_rd_req;
      s_gnt       = ext_rd_gnt;
      s_addr      = ext_rd_addr;
      @(posedge clk); #1;
      if (s_rst) begin
        beat = 0; req_cnt = 0; mem_rdata_valid = 1'b0;
      end else begin
        mem_rdata_valid = s_rd_fire;
        if (s_rd_fire) mem_rdata = 32'hA0 + 32'(s_raddr[4:0]);
        if (s_req && s_gnt) begin
          beat = 0; req_cnt = 0; fill_base = s_addr;
        end else if (s_req) begin
          req_cnt++;
        end
        if (s_fill_fire) beat++;
      end
      ext_rd_gnt   = (gnt_delay == 0) ? 1'b1 : (req_cnt >= gnt_delay);
      ext_rd_data  = fill_base + 32'(beat);
      ext_rd_valid = bp ? 1'($urandom) : 1'b1;
      mem_wready   = bp ? 1'($urandom) : 1'b1;
      mem_rready   = bp ? 1'($urandom) : 1'b1;
      ext_wr_ready = bp ? 1'($urandom) : 1'b1;
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    int lat;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fetch_gnt) begin
          gnt_cyc = cyc;
          if (b2b_wait) begin
            check("b2b_gnt_gap", 128'(cyc - done_cyc), 128'(1));
            b2b_wait = 0; b2b_armed = 0;
          end
        end
        if (mem_wen) begin
          check("wb_before_fill", 128'(exp_wr.size()), 128'(0));
          check("mem_wen_expected", 128'(exp_mem.size() != 0), 128'(1));
          if (exp_mem.size() != 0) check("mem_write", 128'({mem_waddr, mem_wdata}), 128'(exp_mem.pop_front()));
        end
        if (ext_wr_valid) begin
          check("wb_expected", 128'(exp_wr.size() != 0), 128'(1));
          if (exp_wr.size() != 0) begin
            check("wb_beat", 128'({ext_wr_addr, ext_wr_data, ext_wr_last}), 128'(exp_wr[0]));
            if (ext_wr_ready) void'(exp_wr.pop_front());
          end
        end
        if (fetch_done) begin
          check("done_expected", 128'(exp_done.size() != 0), 128'(1));
          if (exp_done.size() != 0) begin
            lat = exp_done.pop_front();
            if (lat >= 0) check("done_latency", 128'(cyc - gnt_cyc), 128'(lat));
          end
          done_cyc = cyc;
          if (b2b_armed) b2b_wait = 1;
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; fetch_req = 1'b0; fetch_cmd = '0; fetch_tag = '0;
    fetch_addr = '0; fetch_addr_pre = '0;
    #3;
    check("rst_ctl", 128'({fetch_gnt, fetch_done, mem_ren, mem_wen, ext_rd_req,
                           ext_rd_ready, ext_wr_valid, ext_wr_last}), 128'(0));
    check("rst_addr", 128'({mem_raddr, mem_waddr, ext_rd_addr, ext_wr_addr}), 128'(0));
    check("rst_data", 128'({mem_wdata, ext_wr_data}), 128'(0));
    fetch_req = 1'b1; #1;
    check("rst_gnt_follows_req", 128'(fetch_gnt), 128'(1));
    fetch_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Fill only, zero-wait.
    push_fill(2'd2, 32'h1000, 32); exp_done.push_back(34);
    issue(2'b01, 2'd2, 32'h1000, 32'h0);
    wait_drain("fill_only", 200);

    // Write-back then fill, zero-wait.
    push_wb(32'h2000); push_fill(2'd1, 32'h3000, 32); exp_done.push_back(130);
    issue(2'b10, 2'd1, 32'h3000, 32'h2000);
    wait_drain("writeback", 400);

    // Write-back then fill under random backpressure.
    bp = 1;
    push_wb(32'h5000); push_fill(2'd3, 32'h4000, 32); exp_done.push_back(-1);
    issue(2'b10, 2'd3, 32'h4000, 32'h5000);
    wait_drain("backpressure", 3000);
    bp = 0;

    // Delayed external read grant.
    gnt_delay = 10;
    push_fill(2'd0, 32'h6000, 32); exp_done.push_back(44);
    issue(2'b01, 2'd0, 32'h6000, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rd_req_held", 128'({ext_rd_req, ext_rd_addr, mem_wen}), 128'({1'b1, 32'h6000, 1'b0}));
    end
    wait_drain("gnt_delay", 200);
    gnt_delay = 0;

    // Back-to-back requests with fetch_req held high.
    b2b_armed = 1;
    push_fill(2'd1, 32'h7000, 32); exp_done.push_back(34);
    push_fill(2'd2, 32'h8000, 32); exp_done.push_back(34);
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_cmd = 2'b01; fetch_tag = 2'd1; fetch_addr = 32'h7000;
    wait_gnt("b2b_gnt1");
    @(posedge clk); #1;
    fetch_cmd = 2'b11; fetch_tag = 2'd2; fetch_addr = 32'h8000;
    for (int i = 0; i < 2; i++) @(negedge clk);
    wait_gnt("b2b_gnt2");
    @(posedge clk); #1;
    fetch_req = 1'b0;
    wait_drain("back_to_back", 200);
    check("b2b_gap_checked", 128'(b2b_armed), 128'(0));

    // Reset mid-FILL after 7 beats.
    push_fill(2'd3, 32'h9000, 7);
    issue(2'b01, 2'd3, 32'h9000, 32'h0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (exp_mem.size() == 0) break;
    end
    check("rst_beats_before", 128'(exp_mem.size()), 128'(0));
    rst_n = 1'b0; #1;
    check("midrst_ctl", 128'({fetch_gnt, fetch_done, mem_ren, mem_wen, ext_rd_req,
                              ext_rd_ready, ext_wr_valid, ext_wr_last}), 128'(0));
    check("midrst_addr", 128'({mem_raddr, mem_waddr, ext_rd_addr, ext_wr_addr}), 128'(0));
    check("midrst_data", 128'({mem_wdata, ext_wr_data}), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    push_fill(2'd0, 32'hB000, 32); exp_done.push_back(34);
    issue(2'b00, 2'd0, 32'hB000, 32'h0);
    wait_drain("after_reset", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
